window_3x3_gen: RTL and testbench
=================================

Name: window_3x3_gen

Overview:
- Converts a raster pixel stream (one 8-bit pixel per in_valid, left-to-right, top-to-bottom) into a sliding 3x3 neighbourhood for the Sobel stage downstream.
- Buffers the two previous lines in two line_ram instances and keeps a 3-column shift register.
- Emits one window per interior pixel; border centres are not emitted.

Parameters:
IMG_W, 640, pixels per line (>= 3)
IMG_H, 480, lines per frame (>= 3)
ADDR_BITS, 10, column counter / line RAM address width; 2**ADDR_BITS >= IMG_W
Y_BITS, 9, row counter width; 2**Y_BITS >= IMG_H

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  in_pixel is valid this cycle; gaps allowed, no backpressure
in_pixel  in  8  greyscale pixel
in_sof  in  1  qualified by in_valid; marks pixel (0,0) of a frame
out_valid  out  1  out_win valid this cycle (single-cycle pulse per window)
out_win  out  72  window; p[r][c] at bits 8*(3r+c)+:8, r=0 top (oldest line), c=0 left (oldest column)
out_cx  out  ADDR_BITS  centre column (only with WIN_COORD_EN)
out_cy  out  Y_BITS  centre row (only with WIN_COORD_EN)

Behaviour:
- Reset: x=0, y=0, all pipeline valids 0, out_valid=0, out_win=0, out_cx=0, out_cy=0. Line RAM contents are not cleared.
- Counters: advance only on in_valid.
  - x==IMG_W-1 -> x=0, y+=1.
  - Additionally y==IMG_H-1 -> y=0.
- in_sof with in_valid forces the current pixel to (0,0) (next x=1, y=0), regardless of counter state.
- Stage 0 (cycle t, in_valid): issue raddr=x to both RAMs; register pixel, x, y, valid into stage 1.
- Stage 1 (t+1):
  - rdA = line y-1, rdB = line y-2.
  - Write ramA[x_d1] <= pixel_d1 and ramB[x_d1] <= rdA.
  - No read/write address conflict arises, since the read of a column always precedes its write by one cycle.
  - If valid_d1, shift column {rdB, rdA, pixel_d1} into the window (c2 <- new, c1 <- c2, c0 <- c1).
  - Register out_valid = valid_d1 && x_d1>=2 && y_d1>=2.
- Latency: exactly 2 clk from in_valid of pixel (x,y) to out_valid for the window centred at (x-1,y-1). Input gaps delay output by the same number of cycles.
- Output count: (IMG_W-2)*(IMG_H-2) windows per frame. Windows spanning a line wrap or the first two lines are suppressed by the gating, so stale RAM or column data is never emitted.
- out_win holds its value when out_valid=0.
- Mid-frame in_sof: in-flight windows (already in stage 1) still complete. Stale RAM data is never exposed because y<2 is gated.
- Reset mid-frame: pipeline flushed. The next accepted pixel is treated as (0,0) even without in_sof.

Optional Feature:
- Macro: WIN_COORD_EN.
- Defined: ports out_cx/out_cy exist. Their values are registered alongside out_valid and equal (x_d1-1, y_d1-1).
- Undefined: these ports and their registers are absent, and the port list ends at out_win.

Decomposition:
- Package win_pkg:
  - PIX_W=8, WIN_N=3
  - typedef pixel_t (logic [7:0])
  - typedef window_t (pixel_t [0:8])
  - function win_idx(r,c) = 3r+c
- Sub-module: existing line_ram, instantiated twice (ramA, ramB) with DEPTH=IMG_W, ADDR_BITS=ADDR_BITS.
- Counters and window registers stay in the top module.

Test Plan:
- Bench parameters: IMG_W=8, IMG_H=6. Pixel value = 16*y+x.
- Test 1, one frame, continuous in_valid:
  - Exactly 24 windows.
  - First window arrives 2 cycles after pixel (2,2), centre (1,1), out_win = {0,1,2,16,17,18,32,33,34} in p[0][0]..p[2][2] order.
  - Last window has centre (6,4): p[2][2]=0x57.
- Test 2, same frame with in_valid randomly 50% duty -> identical 24 windows in identical order. out_valid never set during gaps. out_win stable while out_valid=0.
- Test 3, two back-to-back frames, second frame values +100:
  - Second frame yields 24 windows containing only second-frame values.
  - Its first window has p[0][0]=100.
  - No window mixes frames.
- Test 4, in_sof asserted at pixel (3,3) of frame 1:
  - Windows up to centre (2,2) are emitted.
  - The counter then restarts. The next window is centred (1,1) of the new frame, 2 cycles after its pixel (2,2).
- Test 5, rst pulsed for 1 cycle at pixel (5,2):
  - out_valid=0 and out_win=0 the cycle after.
  - The next pixel is treated as (0,0), and no window appears until its (2,2).
- Test 6, WIN_COORD_EN defined, one frame -> out_cx/out_cy step (1,1),(2,1)..(6,4) in raster order, matching each out_valid.

Source files
------------

// File: rtl/window_3x3_gen_pkg.sv
// Shared types and helpers for the 3x3 window generator.
// Window layout: p[r][c] lives at flat index 3r+c (r=0 oldest line, c=0 oldest column).
package win_pkg;

    localparam int PIX_W    = 8;
    localparam int WIN_N    = 3;
    localparam int WIN_BITS = PIX_W * WIN_N * WIN_N;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef pixel_t [0:WIN_N*WIN_N-1] window_t;

    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
        return WIN_N * r + c;
    endfunction

endpackage

// File: rtl/window_3x3_gen_line_ram.sv
// Simple dual-port line buffer: registered read, one write port, contents never cleared.
module line_ram
    import win_pkg::*;
#(
    parameter int DEPTH     = 640,
    parameter int ADDR_BITS = 10,
    parameter int DATA_W    = PIX_W
) (
    input  logic                 clk,
    input  logic                 i_re,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output logic [DATA_W-1:0]    o_rdata,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic [DATA_W-1:0]    i_wdata
);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/window_3x3_gen.sv
// Raster stream to sliding 3x3 window, one window per interior pixel, 2-cycle latency.
// Optional build macro WIN_COORD_EN adds the out_cx/out_cy centre-coordinate ports.
module window_3x3_gen
    import win_pkg::*;
#(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int ADDR_BITS = 10,
    parameter int Y_BITS    = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [PIX_W-1:0]     in_pixel,
    input  logic                 in_sof,
    output logic                 out_valid,
    output logic [WIN_BITS-1:0]  out_win
`ifdef WIN_COORD_EN
    ,
    output logic [ADDR_BITS-1:0] out_cx,
    output logic [Y_BITS-1:0]    out_cy
`endif
);

    logic [ADDR_BITS-1:0] r_x;
    logic [Y_BITS-1:0]    r_y;
    logic [ADDR_BITS-1:0] w_cur_x;
    logic [Y_BITS-1:0]    w_cur_y;

    pixel_t               r_pix_d1;
    logic [ADDR_BITS-1:0] r_x_d1;
    logic [Y_BITS-1:0]    r_y_d1;
    logic                 r_valid_d1;

    pixel_t               w_rd_a;
    pixel_t               w_rd_b;

    pixel_t [0:2]         r_col_l;
    pixel_t [0:2]         r_col_m;
    pixel_t [0:2]         w_col_new;
    window_t              w_win;
    logic [WIN_BITS-1:0]  w_win_flat;
    logic                 w_emit;

    logic                 r_out_valid;
    logic [WIN_BITS-1:0]  r_out_win;

    // in_sof overrides the counters so the current pixel is always (0,0)
    assign w_cur_x = in_sof ? '0 : r_x;
    assign w_cur_y = in_sof ? '0 : r_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (in_valid) begin
            if (in_sof) begin
                r_x <= ADDR_BITS'(1);
                r_y <= '0;
            end else if (r_x == ADDR_BITS'(IMG_W - 1)) begin
                r_x <= '0;
                r_y <= (r_y == Y_BITS'(IMG_H - 1)) ? '0 : r_y + Y_BITS'(1);
            end else begin
                r_x <= r_x + ADDR_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_d1 <= 1'b0;
            r_pix_d1   <= '0;
            r_x_d1     <= '0;
            r_y_d1     <= '0;
        end else begin
            r_valid_d1 <= in_valid;
            if (in_valid) begin
                r_pix_d1 <= in_pixel;
                r_x_d1   <= w_cur_x;
                r_y_d1   <= w_cur_y;
            end
        end
    end

    // ramA holds line y-1, ramB line y-2; each column is read one cycle before it is rewritten
    line_ram #(
        .DEPTH     (IMG_W),
        .ADDR_BITS (ADDR_BITS),
        .DATA_W    (PIX_W)
    ) u_ram_a (
        .clk     (clk),
        .i_re    (in_valid),
        .i_raddr (w_cur_x),
        .o_rdata (w_rd_a),
        .i_we    (r_valid_d1),
        .i_waddr (r_x_d1),
        .i_wdata (r_pix_d1)
    );

    line_ram #(
        .DEPTH     (IMG_W),
        .ADDR_BITS (ADDR_BITS),
        .DATA_W    (PIX_W)
    ) u_ram_b (
        .clk     (clk),
        .i_re    (in_valid),
        .i_raddr (w_cur_x),
        .o_rdata (w_rd_b),
        .i_we    (r_valid_d1),
        .i_waddr (r_x_d1),
        .i_wdata (w_rd_a)
    );

    assign w_col_new = {w_rd_b, w_rd_a, r_pix_d1};

    always_comb begin
        w_win      = '0;
        w_win_flat = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            w_win[win_idx(r, 0)] = r_col_l[r];
            w_win[win_idx(r, 1)] = r_col_m[r];
            w_win[win_idx(r, 2)] = w_col_new[r];
        end
        for (int unsigned k = 0; k < 9; k++) begin
            w_win_flat[PIX_W*k +: PIX_W] = w_win[k];
        end
    end

    assign w_emit = r_valid_d1 && (r_x_d1 >= ADDR_BITS'(2)) && (r_y_d1 >= Y_BITS'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_l <= '0;
            r_col_m <= '0;
        end else if (r_valid_d1) begin
            r_col_l <= r_col_m;
            r_col_m <= w_col_new;
        end
    end

    // Output is loaded only on emitted windows so it holds between pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_win   <= '0;
        end else begin
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_out_win <= w_win_flat;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_win   = r_out_win;

`ifdef WIN_COORD_EN
    logic [ADDR_BITS-1:0] r_out_cx;
    logic [Y_BITS-1:0]    r_out_cy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_cx <= '0;
            r_out_cy <= '0;
        end else if (w_emit) begin
            r_out_cx <= r_x_d1 - ADDR_BITS'(1);
            r_out_cy <= r_y_d1 - Y_BITS'(1);
        end
    end

    assign out_cx = r_out_cx;
    assign out_cy = r_out_cy;
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen on an 8x6 image; pixel value = offset + 16*y + x.
`timescale 1ns/1ps
module tb_window_3x3_gen;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int AB = 3;
    localparam int YB = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_pixel;
    logic        in_sof;
    logic        out_valid;
    logic [71:0] out_win;
`ifdef WIN_COORD_EN
    logic [AB-1:0] out_cx;
    logic [YB-1:0] out_cy;
`endif

    always #5 clk = ~clk;

    window_3x3_gen #(
        .IMG_W     (W),
        .IMG_H     (H),
        .ADDR_BITS (AB),
        .Y_BITS    (YB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_pixel  (in_pixel),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_win   (out_win)
`ifdef WIN_COORD_EN
        ,
        .out_cx    (out_cx),
        .out_cy    (out_cy)
`endif
    );

    typedef struct {
        logic [71:0] win;
        int          cx;
        int          cy;
        int          due;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [71:0] got[$];
    logic [71:0] ref1[$];
    logic [71:0] prev_win;
    int          img[H][W];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          mx = 0;
    int          my = 0;
    int          t22 = 0;
    int          first_cyc = 0;
    int          last_cx = 0;
    int          last_cy = 0;
    bit          hold_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every out_valid must match the queue head on its due cycle
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_window got=%h required=no_window cyc=%0d", out_win, cyc);
            end else begin
                mon_e = q.pop_front();
                if (out_win !== mon_e.win || cyc != mon_e.due) begin
                    failures++;
                    $display("FAIL window got=%h@%0d required=%h@%0d", out_win, cyc, mon_e.win, mon_e.due);
                end
`ifdef WIN_COORD_EN
                checks++;
                if (out_cx !== AB'(mon_e.cx) || out_cy !== YB'(mon_e.cy)) begin
                    failures++;
                    $display("FAIL coord got=(%0d,%0d) required=(%0d,%0d)", out_cx, out_cy, mon_e.cx, mon_e.cy);
                end
                last_cx = int'(out_cx);
                last_cy = int'(out_cy);
`endif
            end
            got.push_back(out_win);
            if (got.size() == 1) first_cyc = cyc;
        end else begin
            if (q.size() > 0 && q[0].due <= cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_window got=no_window required=%h@%0d", q[0].win, q[0].due);
                void'(q.pop_front());
            end
            if (hold_en) begin
                checks++;
                if (out_win !== prev_win) begin
                    failures++;
                    $display("FAIL hold got=%h required=%h cyc=%0d", out_win, prev_win, cyc);
                end
            end
        end
        prev_win = out_win;
    end

    task automatic drive(input bit v, input int p, input bit sof);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v;
        in_pixel = p[7:0];
        in_sof   = sof;
        if (v) begin
            if (sof) begin
                mx = 0;
                my = 0;
            end
            img[my][mx] = p;
            if (mx == 2 && my == 2) t22 = cyc;
            if (mx >= 2 && my >= 2) begin
                e.win = '0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        e.win[8*(3*r+c) +: 8] = img[my-2+r][mx-2+c][7:0];
                e.cx  = mx - 1;
                e.cy  = my - 1;
                e.due = cyc + 2;
                q.push_back(e);
            end
            if (mx == W - 1) begin
                mx = 0;
                my = (my == H - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 1'b0);
    endtask

    task automatic send_frame(input int off, input bit gaps, input bit sof_first);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                if (gaps)
                    while ($urandom % 2 == 0) drive(1'b0, 0, 1'b0);
                drive(1'b1, off + 16*y + x, sof_first && x == 0 && y == 0);
            end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_pixel = '0;
        in_sof = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_win !== '0) begin
            failures++;
            $display("FAIL reset_state got=%b/%h required=0/0", out_valid, out_win);
        end
`ifdef WIN_COORD_EN
        checks++;
        if (out_cx !== '0 || out_cy !== '0) begin
            failures++;
            $display("FAIL reset_coord got=(%0d,%0d) required=(0,0)", out_cx, out_cy);
        end
`endif
        drive(1'b0, 0, 1'b0);
        hold_en = 1'b1;
    endtask

    task automatic test_continuous();
        int          fw[9] = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
        logic [71:0] first_exp;
        got.delete();
        send_frame(0, 1'b0, 1'b1);
        idle(4);
        first_exp = '0;
        for (int k = 0; k < 9; k++) first_exp[8*k +: 8] = fw[k][7:0];
        checks++;
        if (got.size() != 24) begin
            failures++;
            $display("FAIL cont_count got=%0d required=24", got.size());
        end
        checks++;
        if (first_cyc != t22 + 2) begin
            failures++;
            $display("FAIL cont_latency got=%0d required=%0d", first_cyc, t22 + 2);
        end
        checks++;
        if (got[0] !== first_exp) begin
            failures++;
            $display("FAIL cont_first got=%h required=%h", got[0], first_exp);
        end
        checks++;
        if (got[23][71:64] !== 8'h57) begin
            failures++;
            $display("FAIL cont_last got=%h required=57", got[23][71:64]);
        end
        ref1 = got;
    endtask

    task automatic test_gaps();
        got.delete();
        send_frame(0, 1'b1, 1'b1);
        idle(4);
        checks++;
        if (got.size() != 24) begin
            failures++;
            $display("FAIL gaps_count got=%0d required=24", got.size());
        end
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (got[i] !== ref1[i]) begin
                failures++;
                $display("FAIL gaps_order idx=%0d got=%h required=%h", i, got[i], ref1[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit         mixed = 1'b0;
        logic [7:0] b;
        got.delete();
        send_frame(0, 1'b0, 1'b1);
        send_frame(100, 1'b0, 1'b1);
        idle(4);
        checks++;
        if (got.size() != 48) begin
            failures++;
            $display("FAIL b2b_count got=%0d required=48", got.size());
        end
        checks++;
        if (got[24][7:0] !== 8'd100) begin
            failures++;
            $display("FAIL b2b_first got=%0d required=100", got[24][7:0]);
        end
        for (int i = 0; i < 48; i++)
            for (int k = 0; k < 9; k++) begin
                b = got[i][8*k +: 8];
                if ((i < 24) ? (b >= 8'd100) : (b < 8'd100)) mixed = 1'b1;
            end
        checks++;
        if (mixed !== 1'b0) begin
            failures++;
            $display("FAIL b2b_mixed got=1 required=0");
        end
    endtask

    task automatic test_mid_sof();
        got.delete();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < W; x++)
                if (y < 3 || x <= 3) drive(1'b1, 16*y + x, x == 0 && y == 0);
        send_frame(50, 1'b0, 1'b1);
        idle(4);
        checks++;
        if (got.size() != 32) begin
            failures++;
            $display("FAIL sof_count got=%0d required=32", got.size());
        end
        checks++;
        if (got[7][71:64] !== 8'h33) begin
            failures++;
            $display("FAIL sof_last_old got=%h required=33", got[7][71:64]);
        end
        checks++;
        if (got[8][7:0] !== 8'd50) begin
            failures++;
            $display("FAIL sof_first_new got=%0d required=50", got[8][7:0]);
        end
    endtask

    task automatic test_reset_mid();
        exp_t keep[$];
        got.delete();
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < W; x++)
                if (y < 2 || x <= 4) drive(1'b1, 16*y + x, x == 0 && y == 0);
        hold_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b1;
        in_pixel = 8'h25;
        in_sof = 1'b0;
        foreach (q[i]) if (q[i].due <= cyc) keep.push_back(q[i]);
        q = keep;
        mx = 0;
        my = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_win !== '0) begin
            failures++;
            $display("FAIL rstmid_state got=%b/%h required=0/0", out_valid, out_win);
        end
        drive(1'b0, 0, 1'b0);
        hold_en = 1'b1;
        send_frame(120, 1'b0, 1'b0);
        idle(4);
        checks++;
        if (got.size() != 26) begin
            failures++;
            $display("FAIL rstmid_count got=%0d required=26", got.size());
        end
        checks++;
        if (got[2][7:0] !== 8'd120) begin
            failures++;
            $display("FAIL rstmid_first got=%0d required=120", got[2][7:0]);
        end
    endtask

`ifdef WIN_COORD_EN
    task automatic test_coords();
        got.delete();
        send_frame(0, 1'b0, 1'b1);
        idle(4);
        checks++;
        if (got.size() != 24 || last_cx != 6 || last_cy != 4) begin
            failures++;
            $display("FAIL coord_last got=%0d@(%0d,%0d) required=24@(6,4)", got.size(), last_cx, last_cy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_continuous();
        test_gaps();
        test_back_to_back();
        test_mid_sof();
        test_reset_mid();
`ifdef WIN_COORD_EN
        test_coords();
`endif
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
